// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: FSM states,
// next-PC source codes and the instruction-alignment check.
package pc_pkg;

    // Control FSM states; the 2'b11 encoding is unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } pc_state_e;

    // Next-PC source select codes (2'b11 is reserved and behaves as sequential)
    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JR  = 2'b10;
    localparam logic [1:0] SRC_RSV = 2'b11;

    // Low PC bits that must be zero for a 4-byte aligned instruction fetch
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    // True when the given low address bits do not form a word-aligned target
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return ((low_bits & MISALIGN_MASK) != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential, PC-relative branch/JAL and
// register-indirect JALR targets, plus a flag for misaligned redirect targets.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int INC  = 4
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [1:0]      pcsrc_i,
    input  logic [XLEN-1:0] immext_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] INC_V   = XLEN'(INC);
    // JALR clears bit 0 of the computed address
    localparam logic [XLEN-1:0] JR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] seq_s;
    logic [XLEN-1:0] br_s;
    logic [XLEN-1:0] jr_s;

    // Candidate targets; all additions wrap modulo 2^XLEN
    always_comb begin
        seq_s = pc_i + INC_V;
        br_s  = pc_i + immext_i;
        jr_s  = (rs1_i + immext_i) & JR_MASK;
    end

    // Pick the requested target; only redirects can be misaligned
    always_comb begin
        next_pc_o  = seq_s;
        misalign_o = 1'b0;
        case (pcsrc_i)
            SRC_SEQ: begin
                next_pc_o  = seq_s;
                misalign_o = 1'b0;
            end
            SRC_BR: begin
                next_pc_o  = br_s;
                misalign_o = is_misaligned(br_s[1:0]);
            end
            SRC_JR: begin
                next_pc_o  = jr_s;
                misalign_o = is_misaligned(jr_s[1:0]);
            end
            default: begin
                next_pc_o  = seq_s;
                misalign_o = 1'b0;
            end
        endcase
    end

    assign pc_plus_o = seq_s;

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator for the single-cycle core: holds the PC, EPC and
// retired-instruction count and sequences run / pause / trap behaviour.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              INC          = 4,
    parameter int              CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             r_en_i,
    input  logic             stall_i,
    input  logic [1:0]       pcsrc_i,
    input  logic [XLEN-1:0]  immext_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic             trap_req_i,
    input  logic             mret_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus_o,
    output logic [XLEN-1:0]  epc_o,
    output logic             misalign_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pc_state_e        state_q,    state_d;
    logic [XLEN-1:0]  pc_q,       pc_d;
    logic [XLEN-1:0]  epc_q,      epc_d;
    logic [CNT_W-1:0] retired_q,  retired_d;
    logic             misalign_q, misalign_d;

    logic [XLEN-1:0]  next_pc_s;
    logic             tgt_misalign_s;

    pc_next_mux #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_next_mux (
        .pc_i       (pc_q),
        .pcsrc_i    (pcsrc_i),
        .immext_i   (immext_i),
        .rs1_i      (rs1_i),
        .next_pc_o  (next_pc_s),
        .pc_plus_o  (pc_plus_o),
        .misalign_o (tgt_misalign_s)
    );

    // Next-state logic: pause beats everything in RUN, then trap request,
    // misaligned redirect, MRET, stall and finally the selected target
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        retired_d  = retired_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (r_en_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!r_en_i) begin
                    state_d = ST_IDLE;
                end else if (trap_req_i || tgt_misalign_s) begin
                    // Misaligned target is never loaded; an external request
                    // takes precedence as the reported cause
                    epc_d      = pc_q;
                    pc_d       = TRAP_VECTOR;
                    state_d    = ST_TRAP;
                    misalign_d = ~trap_req_i;
                end else if (mret_i) begin
                    pc_d      = epc_q;
                    retired_d = retired_q + CNT_ONE;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else begin
                    pc_d      = next_pc_s;
                    retired_d = retired_q + CNT_ONE;
                end
            end
            ST_TRAP: begin
                // Single flush slot at the trap vector
                if (r_en_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC, EPC, counter and misalign-pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            epc_q      <= {XLEN{1'b0}};
            retired_q  <= {CNT_W{1'b0}};
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            retired_q  <= retired_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign epc_o      = epc_q;
    assign misalign_o = misalign_q;
    assign state_o    = state_q;
    assign retired_o  = retired_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural reference model.
module tb_pc_gen_unit;

    localparam int          XLEN  = 32;
    localparam int          CNT_W = 8;
    localparam logic [31:0] TV    = 32'h0000_0100;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             r_en_i;
    logic             stall_i;
    logic [1:0]       pcsrc_i;
    logic [XLEN-1:0]  immext_i;
    logic [XLEN-1:0]  rs1_i;
    logic             trap_req_i;
    logic             mret_i;
    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  pc_plus_o;
    logic [XLEN-1:0]  epc_o;
    logic             misalign_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] retired_o;

    pc_gen_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (TV),
        .INC          (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .r_en_i     (r_en_i),
        .stall_i    (stall_i),
        .pcsrc_i    (pcsrc_i),
        .immext_i   (immext_i),
        .rs1_i      (rs1_i),
        .trap_req_i (trap_req_i),
        .mret_i     (mret_i),
        .pc_o       (pc_o),
        .pc_plus_o  (pc_plus_o),
        .epc_o      (epc_o),
        .misalign_o (misalign_o),
        .state_o    (state_o),
        .retired_o  (retired_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = paused, 1 = running, 2 = trap flush slot
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    int          m_ret;
    int          m_mode;
    bit          m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},       pc_o,                 m_pc);
        check({tag, ".pc_plus"},  pc_plus_o,            m_pc + 32'd4);
        check({tag, ".epc"},      epc_o,                m_epc);
        check({tag, ".misalign"}, {31'd0, misalign_o},  {31'd0, m_mis});
        check({tag, ".state"},    {30'd0, state_o},     32'(m_mode));
        check({tag, ".retired"},  {24'd0, retired_o},   32'(m_ret));
    endtask

    task automatic model_reset();
        m_pc   = 32'd0;
        m_epc  = 32'd0;
        m_ret  = 0;
        m_mode = 0;
        m_mis  = 1'b0;
    endtask

    // One clock of the architectural rules, using the inputs applied this cycle
    task automatic model_step();
        logic [31:0] target;
        bit          redirect;
        bit          bad;
        m_mis = 1'b0;
        if (m_mode == 0) begin
            if (r_en_i) m_mode = 1;
        end else if (m_mode == 2) begin
            m_mode = r_en_i ? 1 : 0;
        end else if (!r_en_i) begin
            m_mode = 0;
        end else begin
            redirect = (pcsrc_i == 2'd1) || (pcsrc_i == 2'd2);
            if (pcsrc_i == 2'd1)      target = m_pc + immext_i;
            else if (pcsrc_i == 2'd2) target = (rs1_i + immext_i) & 32'hFFFF_FFFE;
            else                      target = m_pc + 32'd4;
            bad = redirect && ((target % 32'd4) != 32'd0);
            if (trap_req_i || bad) begin
                m_epc  = m_pc;
                m_pc   = TV;
                m_mode = 2;
                m_mis  = !trap_req_i;
            end else if (mret_i) begin
                m_pc  = m_epc;
                m_ret = (m_ret + 1) % (1 << CNT_W);
            end else if (!stall_i) begin
                m_pc  = target;
                m_ret = (m_ret + 1) % (1 << CNT_W);
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk_i);
        #1;
        model_step();
        check_all(tag);
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] src,
                         input logic [31:0] imm, input logic [31:0] rs1,
                         input logic trap, input logic mret);
        r_en_i     = r;
        stall_i    = s;
        pcsrc_i    = src;
        immext_i   = imm;
        rs1_i      = rs1;
        trap_req_i = trap;
        mret_i     = mret;
    endtask

    initial begin
        // Reset state
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_all("reset");
        rst_ni = 1'b1;

        // Sequential fetch: first enabled cycle enters RUN, then 0->4->8->12
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("t1_start");
        for (int i = 0; i < 3; i++) step("t1_seq");
        check("t1_pc_12",  pc_o,               32'd12);
        check("t1_ret_3",  {24'd0, retired_o}, 32'd3);
        check("t1_run",    {30'd0, state_o},   32'd1);

        // Branch back by 8, then JALR to a misaligned target
        step("t2_seq");
        check("t2_pc_10", pc_o, 32'h10);
        drive(1'b1, 1'b0, 2'd1, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0);
        step("t2_br");
        check("t2_pc_08", pc_o, 32'h08);
        drive(1'b1, 1'b0, 2'd2, 32'd0, 32'h23, 1'b0, 1'b0);
        step("t2_jr");
        check("t2_misalign", {31'd0, misalign_o}, 32'd1);
        check("t2_epc",      epc_o,               32'h08);
        check("t2_pc_trap",  pc_o,                TV);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("t2_flush");
        check("t2_mis_clear", {31'd0, misalign_o}, 32'd0);

        // Trap request overriding stall, then MRET back to the EPC
        drive(1'b1, 1'b0, 2'd1, 32'hFFFF_FF40, 32'd0, 1'b0, 1'b0);
        step("t3_br");
        check("t3_pc_40", pc_o, 32'h40);
        drive(1'b1, 1'b1, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step("t3_trap");
        check("t3_epc",   epc_o,             32'h40);
        check("t3_state", {30'd0, state_o},  32'd2);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("t3_flush");
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step("t3_mret");
        check("t3_pc_ret", pc_o,               32'h40);
        check("t3_ret_7",  {24'd0, retired_o}, 32'd7);

        // Stall holds, pause holds, resume continues sequentially
        drive(1'b1, 1'b0, 2'd1, 32'hFFFF_FFE0, 32'd0, 1'b0, 1'b0);
        step("t4_br");
        drive(1'b1, 1'b1, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("t4_stall");
        check("t4_pc_20", pc_o,               32'h20);
        check("t4_ret_8", {24'd0, retired_o}, 32'd8);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("t4_pause");
        step("t4_idle");
        check("t4_idle_st", {30'd0, state_o}, 32'd0);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("t4_resume");
        step("t4_seq");
        check("t4_pc_24", pc_o, 32'h24);

        // PC wrap-around and retired-counter wrap
        drive(1'b1, 1'b0, 2'd1, 32'hFFFF_FFD8, 32'd0, 1'b0, 1'b0);
        step("t5_br");
        check("t5_pc_top", pc_o, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("t5_wrap");
        check("t5_pc_0", pc_o, 32'd0);
        for (int i = 0; i < 300 && m_ret != 255; i++) step("t5_cnt");
        check("t5_ret_max", {24'd0, retired_o}, 32'd255);
        step("t5_cnt_wrap");
        check("t5_ret_0", {24'd0, retired_o}, 32'd0);

        // Random stimulus against the model
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 15) != 0,
                  $urandom_range(0, 5) == 0,
                  2'($urandom_range(0, 3)),
                  32'($urandom_range(0, 95)) - 32'd48,
                  32'($urandom_range(0, 255)),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0);
            step("rnd");
        end

        // Asynchronous reset while sitting in the trap slot
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("t6_run_a");
        step("t6_run_b");
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step("t6_trap");
        check("t6_in_trap", {30'd0, state_o}, 32'd2);
        #3;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check("t6_pc",       pc_o,                32'd0);
        check("t6_epc",      epc_o,               32'd0);
        check("t6_retired",  {24'd0, retired_o},  32'd0);
        check("t6_state",    {30'd0, state_o},    32'd0);
        check("t6_misalign", {31'd0, misalign_o}, 32'd0);
        #1;
        rst_ni = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("t6_restart");
        step("t6_seq");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
